// File: rtl/mini_cpu_pkg.sv
// Shared widths, opcode encodings and compare-result codes for the mini_cpu slice.
package mini_cpu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;

    typedef logic [OP_W-1:0]   opcode_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam opcode_t OP_CLR = 4'h0;
    localparam opcode_t OP_LD1 = 4'h1;
    localparam opcode_t OP_LD2 = 4'h2;
    localparam opcode_t OP_MOV = 4'h3;
    localparam opcode_t OP_ADD = 4'h4;
    localparam opcode_t OP_SHL = 4'h5;
    localparam opcode_t OP_SHR = 4'h6;
    localparam opcode_t OP_AND = 4'h7;
    localparam opcode_t OP_OR  = 4'h8;
    localparam opcode_t OP_CMP = 4'h9;

    localparam data_t CMP_LT = 8'h01;
    localparam data_t CMP_EQ = 8'h02;
    localparam data_t CMP_GT = 8'h04;

    // True for the opcodes whose outcome lands in Rout/overflow.
    function automatic logic is_alu_op(input opcode_t op);
        return (op >= OP_ADD) && (op <= OP_CMP);
    endfunction

endpackage

// File: rtl/mini_cpu_alu.sv
// Combinational ALU: computes Rout and overflow candidates from R1/R2 for the arithmetic/logic opcodes.
module mini_cpu_alu
    import mini_cpu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] r1,
    input  logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, r1} + {1'b0, r2};

    // Select the operation result; non-ALU opcodes produce don't-care zeros.
    always_comb begin
        // NOTE: defaults before the case keep every path assigned, so no latch is inferred.
        result   = '0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                result   = sum[DATA_W-1:0];
                overflow = sum[DATA_W];
            end
            OP_SHL: begin
                result   = {r2[DATA_W-2:0], 1'b0};
                overflow = r2[DATA_W-1];
            end
            OP_SHR: result = {1'b0, r2[DATA_W-1:1]};
            OP_AND: result = r1 & r2;
            OP_OR:  result = r1 | r2;
            OP_CMP: begin
                if (r1 < r2)       result = CMP_LT;
                else if (r1 == r2) result = CMP_EQ;
                else               result = CMP_GT;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mini_cpu.sv
// Accumulator-style 8-bit CPU: executes one externally supplied 12-bit instruction per clock.
module mini_cpu
    import mini_cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [11:0]       in,
    output logic              overflow,
    output logic [DATA_W-1:0] out
);

    opcode_t           op;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic [DATA_W-1:0] rout;
    logic              ovf;
    logic [DATA_W-1:0] alu_result;
    logic              alu_overflow;

    logic              do_clr;
    logic              we_r1;
    logic              we_r2;
    logic              we_res;
    logic [DATA_W-1:0] r2_next;

    assign op  = in[11:8];
    assign imm = in[DATA_W-1:0];

    mini_cpu_alu u_alu (
        .op       (op),
        .r1       (r1),
        .r2       (r2),
        .result   (alu_result),
        .overflow (alu_overflow)
    );

    // Decode the opcode into per-register write enables; 0xA-0xF assert nothing.
    always_comb begin
        do_clr  = (op == OP_CLR);
        we_r1   = (op == OP_LD1);
        we_r2   = (op == OP_LD2) || (op == OP_MOV);
        we_res  = is_alu_op(op);
        r2_next = (op == OP_MOV) ? rout : imm;
    end

    // Architectural state: cleared asynchronously by reset or by CLR, else updated under write enables.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking updates let every register sample pre-edge values, which keeps MOV/ADD order-free.
        if (reset) begin
            r1   <= '0;
            r2   <= '0;
            rout <= '0;
            ovf  <= 1'b0;
        end else if (do_clr) begin
            r1   <= '0;
            r2   <= '0;
            rout <= '0;
            ovf  <= 1'b0;
        end else begin
            if (we_r1)  r1 <= imm;
            if (we_r2)  r2 <= r2_next;
            if (we_res) begin
                rout <= alu_result;
                ovf  <= alu_overflow;
            end
        end
    end

    assign out      = rout;
    assign overflow = ovf;

endmodule

// File: tb/tb_mini_cpu.sv
// Directed self-checking bench for mini_cpu: hand-computed expectations per scenario.
module tb_mini_cpu;

    logic        clock;
    logic        reset;
    logic [11:0] in;
    logic        overflow;
    logic [7:0]  out;

    int checks   = 0;
    int failures = 0;

    mini_cpu dut (
        .clock    (clock),
        .reset    (reset),
        .in       (in),
        .overflow (overflow),
        .out      (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present an instruction on the falling edge, let one rising edge execute it, sample 1 time unit later.
    task automatic exec(input logic [11:0] instr);
        @(negedge clock);
        in = instr;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        exec(12'h105);
        exec(12'h205);
        exec(12'h400);
        checks++;
        if (out !== 8'h0A) begin
            failures++;
            $display("FAIL pre_reset_add out=%h exp=%h", out, 8'h0A);
        end
        // Assert reset between edges and look before the next rising edge.
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out !== 8'h00 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL async_reset out=%h ovf=%b exp=00/0", out, overflow);
        end
        @(negedge clock);
        reset = 1'b0;
        exec(12'h000);
        checks++;
        if (out !== 8'h00 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL clr_after_reset out=%h ovf=%b exp=00/0", out, overflow);
        end
        // R1/R2 must have been cleared too: ADD of zeros.
        exec(12'h400);
        checks++;
        if (out !== 8'h00 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_cleared_regs out=%h ovf=%b exp=00/0", out, overflow);
        end
    endtask

    task automatic test_arith();
        exec(12'h107);
        exec(12'h208);
        exec(12'h400);
        checks++;
        if (out !== 8'h0F || overflow !== 1'b0) begin
            failures++;
            $display("FAIL add_7_8 out=%h ovf=%b exp=0f/0", out, overflow);
        end
        exec(12'h800);
        checks++;
        if (out !== 8'h0F) begin
            failures++;
            $display("FAIL or_7_8 out=%h exp=0f", out);
        end
        exec(12'h900);
        checks++;
        if (out !== 8'h01) begin
            failures++;
            $display("FAIL cmp_lt out=%h exp=01", out);
        end
        exec(12'h500);
        checks++;
        if (out !== 8'h10 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL shl_8 out=%h ovf=%b exp=10/0", out, overflow);
        end
        exec(12'h300);
        checks++;
        if (out !== 8'h10) begin
            failures++;
            $display("FAIL mov_keeps_out out=%h exp=10", out);
        end
        exec(12'h600);
        checks++;
        if (out !== 8'h08 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL shr_16 out=%h ovf=%b exp=08/0", out, overflow);
        end
        exec(12'h700);
        checks++;
        if (out !== 8'h00) begin
            failures++;
            $display("FAIL and_7_16 out=%h exp=00", out);
        end
    endtask

    task automatic test_overflow();
        exec(12'h000);
        exec(12'h187);
        exec(12'h288);
        exec(12'h400);
        checks++;
        if (out !== 8'h0F || overflow !== 1'b1) begin
            failures++;
            $display("FAIL add_carry out=%h ovf=%b exp=0f/1", out, overflow);
        end
        exec(12'h500);
        checks++;
        if (out !== 8'h10 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL shl_msb out=%h ovf=%b exp=10/1", out, overflow);
        end
    endtask

    task automatic test_cmp();
        exec(12'h155);
        exec(12'h255);
        exec(12'h900);
        checks++;
        if (out !== 8'h02 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL cmp_eq out=%h ovf=%b exp=02/0", out, overflow);
        end
        exec(12'h180);
        exec(12'h27F);
        exec(12'h900);
        checks++;
        if (out !== 8'h04) begin
            failures++;
            $display("FAIL cmp_gt_unsigned out=%h exp=04", out);
        end
    endtask

    task automatic test_nop_hold();
        for (int i = 0; i < 3; i++) begin
            exec(12'hBA5);
            checks++;
            if (out !== 8'h04 || overflow !== 1'b0) begin
                failures++;
                $display("FAIL nop_hold_%0d out=%h ovf=%b exp=04/0", i, out, overflow);
            end
        end
        // R1=0x80, R2=0x7F must still be intact.
        exec(12'h400);
        checks++;
        if (out !== 8'hFF || overflow !== 1'b0) begin
            failures++;
            $display("FAIL nop_regs_add out=%h ovf=%b exp=ff/0", out, overflow);
        end
        exec(12'h500);
        checks++;
        if (out !== 8'hFE || overflow !== 1'b0) begin
            failures++;
            $display("FAIL nop_regs_shl out=%h ovf=%b exp=fe/0", out, overflow);
        end
    endtask

    task automatic test_back_to_back();
        exec(12'h000);
        exec(12'h103);
        exec(12'h204);
        for (int i = 0; i < 2; i++) begin
            exec(12'h400);
            checks++;
            if (out !== 8'h07 || overflow !== 1'b0) begin
                failures++;
                $display("FAIL add_held_%0d out=%h ovf=%b exp=07/0", i, out, overflow);
            end
        end
        exec(12'h300);
        exec(12'h300);
        exec(12'h400);
        checks++;
        if (out !== 8'h0A) begin
            failures++;
            $display("FAIL mov_held_add out=%h exp=0a", out);
        end
    endtask

    task automatic test_sticky_overflow();
        exec(12'h000);
        exec(12'h187);
        exec(12'h288);
        exec(12'h400);
        exec(12'h101);
        checks++;
        if (out !== 8'h0F || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_through_ld1 out=%h ovf=%b exp=0f/1", out, overflow);
        end
        exec(12'h201);
        checks++;
        if (out !== 8'h0F || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_through_ld2 out=%h ovf=%b exp=0f/1", out, overflow);
        end
        exec(12'h300);
        checks++;
        if (out !== 8'h0F || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_through_mov out=%h ovf=%b exp=0f/1", out, overflow);
        end
        // R1=1, R2=0x0F after MOV.
        exec(12'h700);
        checks++;
        if (out !== 8'h01 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL and_clears_ovf out=%h ovf=%b exp=01/0", out, overflow);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        in    = 12'h000;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_arith();
        test_overflow();
        test_cmp();
        test_nop_hold();
        test_back_to_back();
        test_sticky_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
